rtc_timekeeper: RTL and testbench
=================================

# rtc_timekeeper

Time-of-day counter that produces the `seconds`, `minutes` and `hours` buses consumed by the dispense-time comparator. It divides the system clock into a 1 Hz tick and counts 24-hour wall time. Time can be loaded from the front panel, and single minute and hour fields can be stepped by push-buttons. All outputs are registered, so the downstream equality compare sees glitch-free values.

## Interface
- `TICKS_PER_SEC`, default 50000000: system-clock cycles per second; must be ≥2. Benches use 4.
- `clock`  in  1  system clock; all logic on posedge.
- `resetn`  in  1  synchronous, active-low reset.
- `set_load`  in  1  level; sampled every cycle; high = load `set_hours`/`set_minutes`.
- `set_hours`  in  5  load value for hours, legal 0–23.
- `set_minutes`  in  6  load value for minutes, legal 0–59.
- `inc_min`  in  1  button level; a rising edge steps minutes.
- `inc_hour`  in  1  button level; a rising edge steps hours.
- `seconds`  out  6  current seconds, 0–59.
- `minutes`  out  6  current minutes, 0–59.
- `hours`  out  5  current hours, 0–23.
- `tick_1hz`  out  1  one-cycle pulse in the cycle the seconds value advances.
- `day_wrap`  out  1  one-cycle pulse when time rolls from 23:59:59 to 00:00:00.
- `set_error`  out  1  one-cycle pulse when a load is rejected.

## Operation
- Reset (`resetn`=0 at a posedge) clears the following: time to 00:00:00, prescaler to 0, all pulse outputs to 0, and both button edge-detect registers to 0.
- Prescaler counts 0..`TICKS_PER_SEC`-1 and wraps. A tick event occurs in the cycle where the prescaler equals `TICKS_PER_SEC`-1.
- Tick advance:
  - seconds+1.
  - At 59, seconds goes to 0 and minutes carries +1.
  - At minutes 59, minutes goes to 0 and hours carries +1.
  - At hours 23, hours goes to 0 and `day_wrap` asserts.
- Button edges:
  - Each button has a previous-value register. Edge = current & ~previous. Holding a button high gives exactly one step.
  - `inc_min` adds 1 to minutes mod 60 with no carry into hours. Seconds are unchanged.
  - `inc_hour` adds 1 to hours mod 24.
- Load (`set_load`=1):
  - If `set_hours`≤23 and `set_minutes`≤59: hours and minutes take the inputs, seconds=0, and the prescaler clears to 0.
  - Otherwise: time and prescaler are unchanged and `set_error` pulses.
  - A held `set_load` reloads on every cycle. This freezes the time display while setting.
- Priority within one cycle:
  1. Load (valid or invalid) overrides tick and button edges. A suppressed edge is consumed, not replayed.
  2. Otherwise, the tick advance is applied first. Button steps are then applied to the post-tick minutes/hours fields.
  - Example: 12:59:59 + tick + `inc_min` edge gives 13:01:00.
- `tick_1hz` asserts only on a tick cycle not overridden by a load.
- `day_wrap` asserts only on a tick rollover. Button-induced wraps (e.g. hours 23 to 0 via `inc_hour`) do not pulse it.

## Timing
- All outputs are registered and update one cycle after the sampling posedge.
- `tick_1hz`/`day_wrap` are coincident with the new time value (e.g. the first cycle showing 00:00:00).
- First tick after reset or after a valid load: the seconds output changes `TICKS_PER_SEC` cycles after the reset/load edge.
- Steady state: exactly one `tick_1hz` every `TICKS_PER_SEC` cycles, with no drift.
- Button step latency: time changes on the posedge after the edge is sampled, i.e. one cycle.
- Reset mid-operation: it takes effect at the next posedge regardless of prescaler, load or buttons. Outputs read 00:00:00 with all pulses 0 the cycle after.

## Test plan
- Reset and count (`TICKS_PER_SEC`=4):
  - Release reset, run 240 cycles.
  - Expect 00:01:00, `tick_1hz` every 4th cycle, 60 pulses total.
- Day rollover:
  - Load 23:59, run 59 ticks, then one more tick.
  - Expect 00:00:00, a single `day_wrap` pulse coincident with `tick_1hz`, and no `day_wrap` elsewhere.
- Load validation:
  - `set_load` with 24:00, then separately 12:60: `set_error` pulses each time and the time is unchanged.
  - `set_load` with 08:00: expect 08:00:00 and the next tick exactly 4 cycles later.
- Button steps:
  - Hold `inc_min` high for 10 cycles at 10:59:30: expect a single step to 10:00:30.
  - `inc_hour` at 23:xx: expect 00:xx with no `day_wrap`.
- Simultaneous events:
  - At 12:59:59, tick cycle plus `inc_min` edge: expect 13:01:00.
  - Tick plus valid load of 07:30: expect 07:30:00 with no `tick_1hz`.
- Mid-operation reset:
  - Assert `resetn`=0 for one cycle at 15:42:17 with prescaler=2 while `set_load` is high.
  - Expect 00:00:00, all pulses 0, and the first tick 4 cycles after release.

Source files
------------

// File: rtl/rtc_timekeeper_if.sv
// Front-panel controls and time-of-day outputs of the RTC timekeeper.
interface rtc_timekeeper_if;
  logic       set_load;
  logic [4:0] set_hours;
  logic [5:0] set_minutes;
  logic       inc_min;
  logic       inc_hour;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       tick_1hz;
  logic       day_wrap;
  logic       set_error;

  // Front panel / bench side
  modport master (
    output set_load, set_hours, set_minutes, inc_min, inc_hour,
    input  seconds, minutes, hours, tick_1hz, day_wrap, set_error
  );

  // Timekeeper side
  modport slave (
    input  set_load, set_hours, set_minutes, inc_min, inc_hour,
    output seconds, minutes, hours, tick_1hz, day_wrap, set_error
  );
endinterface

// File: rtl/rtc_timekeeper.sv
// 24-hour time-of-day counter with 1 Hz prescaler, front-panel load and
// minute/hour push-button stepping. All outputs are registered.
module rtc_timekeeper #(
  parameter int unsigned TICKS_PER_SEC = 50000000
) (
  input logic           clock,
  input logic           resetn,
  rtc_timekeeper_if.slave bus
);

  localparam int unsigned PreW = $clog2(TICKS_PER_SEC);
  localparam logic [PreW-1:0] PreLast = PreW'(TICKS_PER_SEC - 1);

  logic [PreW-1:0] presc_q, presc_d;
  logic [5:0]      sec_q, sec_d;
  logic [5:0]      min_q, min_d;
  logic [4:0]      hr_q, hr_d;
  logic            tick_q, tick_d;
  logic            wrap_q, wrap_d;
  logic            err_q, err_d;
  logic            min_prev_q, hour_prev_q;

  logic tick_event, min_edge, hour_edge, load_valid;

  assign tick_event = (presc_q == PreLast);
  assign min_edge   = bus.inc_min & ~min_prev_q;
  assign hour_edge  = bus.inc_hour & ~hour_prev_q;
  assign load_valid = (bus.set_hours <= 5'd23) && (bus.set_minutes <= 6'd59);

  // Next-state: load overrides everything; otherwise tick first, then button steps
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;

    if (bus.set_load) begin
      // Button edges seen here are consumed (prev regs still update)
      if (load_valid) begin
        hr_d    = bus.set_hours;
        min_d   = bus.set_minutes;
        sec_d   = 6'd0;
        presc_d = '0;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      presc_d = tick_event ? '0 : presc_q + 1'b1;

      if (tick_event) begin
        tick_d = 1'b1;
        if (sec_q == 6'd59) begin
          sec_d = 6'd0;
          if (min_q == 6'd59) begin
            min_d = 6'd0;
            if (hr_q == 5'd23) begin
              hr_d   = 5'd0;
              wrap_d = 1'b1;
            end else begin
              hr_d = hr_q + 5'd1;
            end
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end

      // Steps act on the post-tick fields and never carry
      if (min_edge) begin
        min_d = (min_d == 6'd59) ? 6'd0 : min_d + 6'd1;
      end
      if (hour_edge) begin
        hr_d = (hr_d == 5'd23) ? 5'd0 : hr_d + 5'd1;
      end
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!resetn) begin
      presc_q     <= '0;
      sec_q       <= 6'd0;
      min_q       <= 6'd0;
      hr_q        <= 5'd0;
      tick_q      <= 1'b0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
      min_prev_q  <= 1'b0;
      hour_prev_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hr_q        <= hr_d;
      tick_q      <= tick_d;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
      min_prev_q  <= bus.inc_min;
      hour_prev_q <= bus.inc_hour;
    end
  end

  assign bus.seconds   = sec_q;
  assign bus.minutes   = min_q;
  assign bus.hours     = hr_q;
  assign bus.tick_1hz  = tick_q;
  assign bus.day_wrap  = wrap_q;
  assign bus.set_error = err_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Self-checking bench for rtc_timekeeper: constant vector table, directed
// corner sequences and randomized stimulus against a seconds-of-day model.
module tb_rtc_timekeeper;

  localparam int TPS = 4;
  localparam int DaySec = 86400;

  logic clock = 1'b0;
  logic resetn;

  rtc_timekeeper_if bus ();

  rtc_timekeeper #(.TICKS_PER_SEC(TPS)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: time kept as seconds since midnight
  int m_tod = 0;
  int m_pre = 0;
  bit m_pm  = 1'b0;
  bit m_ph  = 1'b0;
  bit e_tick, e_wrap, e_err;

  typedef struct {
    bit ld;
    int sh;
    int sm;
    bit im;
    bit ih;
    int eh;
    int em;
    int es;
    bit et;
    bit ee;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rn, input bit ld, input int sh, input int sm,
                            input bit im, input bit ih);
    int h, m, s;
    bit tk;
    e_tick = 1'b0;
    e_wrap = 1'b0;
    e_err  = 1'b0;
    if (!rn) begin
      m_tod = 0;
      m_pre = 0;
      m_pm  = 1'b0;
      m_ph  = 1'b0;
      return;
    end
    tk = (m_pre == TPS - 1);
    if (ld) begin
      if (sh <= 23 && sm <= 59) begin
        m_tod = sh * 3600 + sm * 60;
        m_pre = 0;
      end else begin
        e_err = 1'b1;
      end
    end else begin
      m_pre = (m_pre + 1) % TPS;
      if (tk) begin
        m_tod  = (m_tod + 1) % DaySec;
        e_tick = 1'b1;
        e_wrap = (m_tod == 0);
      end
      h = m_tod / 3600;
      m = (m_tod / 60) % 60;
      s = m_tod % 60;
      if (im && !m_pm) m = (m + 1) % 60;
      if (ih && !m_ph) h = (h + 1) % 24;
      m_tod = h * 3600 + m * 60 + s;
    end
    m_pm = im;
    m_ph = ih;
  endtask

  // One clock: drive inputs, advance model, compare all outputs to model
  task automatic cycle(input bit rn, input bit ld, input int sh, input int sm,
                       input bit im, input bit ih);
    int act, exp;
    resetn          = rn;
    bus.set_load    = ld;
    bus.set_hours   = 5'(sh);
    bus.set_minutes = 6'(sm);
    bus.inc_min     = im;
    bus.inc_hour    = ih;
    @(posedge clock);
    model_step(rn, ld, sh, sm, im, ih);
    #1;
    act = {int'(bus.hours), int'(bus.minutes), int'(bus.seconds)} & 32'h1ffff;
    act = (int'(bus.hours) << 16) | (int'(bus.minutes) << 8) | int'(bus.seconds);
    exp = ((m_tod / 3600) << 16) | (((m_tod / 60) % 60) << 8) | (m_tod % 60);
    check("model_time(hh<<16|mm<<8|ss)", act, exp);
    act = {29'd0, bus.tick_1hz, bus.day_wrap, bus.set_error};
    exp = {29'd0, e_tick, e_wrap, e_err};
    check("model_pulses(tick,wrap,err)", act, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0);
  endtask

  task automatic check_time(input string name, input int h, input int m, input int s);
    check({name, "_hours"}, int'(bus.hours), h);
    check({name, "_minutes"}, int'(bus.minutes), m);
    check({name, "_seconds"}, int'(bus.seconds), s);
  endtask

  int ticks, wraps;

  initial begin
    //          ld  sh  sm im ih   eh  em es et ee
    tbl[0]  = '{1, 12, 34, 0, 0, 12, 34, 0, 0, 0};
    tbl[1]  = '{1, 24,  0, 0, 0, 12, 34, 0, 0, 1};
    tbl[2]  = '{1, 12, 60, 0, 0, 12, 34, 0, 0, 1};
    tbl[3]  = '{0,  0,  0, 0, 0, 12, 34, 0, 0, 0};
    tbl[4]  = '{0,  0,  0, 1, 0, 12, 35, 0, 0, 0};
    tbl[5]  = '{0,  0,  0, 1, 0, 12, 35, 0, 0, 0};
    tbl[6]  = '{0,  0,  0, 1, 0, 12, 35, 1, 1, 0};
    tbl[7]  = '{0,  0,  0, 0, 0, 12, 35, 1, 0, 0};
    tbl[8]  = '{1, 23, 59, 0, 0, 23, 59, 0, 0, 0};
    tbl[9]  = '{0,  0,  0, 0, 1,  0, 59, 0, 0, 0};
    tbl[10] = '{0,  0,  0, 0, 0,  0, 59, 0, 0, 0};
    tbl[11] = '{0,  0,  0, 0, 0,  0, 59, 0, 0, 0};
    tbl[12] = '{0,  0,  0, 0, 0,  0, 59, 1, 1, 0};
    tbl[13] = '{1,  8,  0, 1, 0,  8,  0, 0, 0, 0};
    tbl[14] = '{0,  0,  0, 1, 0,  8,  0, 0, 0, 0};
    tbl[15] = '{0,  0,  0, 0, 0,  8,  0, 0, 0, 0};
    tbl[16] = '{0,  0,  0, 0, 0,  8,  0, 0, 0, 0};
    tbl[17] = '{0,  0,  0, 0, 0,  8,  0, 1, 1, 0};

    // Reset state
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 5, 5, 1, 1);
    check_time("reset", 0, 0, 0);
    check("reset_pulses", {bus.tick_1hz, bus.day_wrap, bus.set_error}, 0);

    // Table vectors
    foreach (tbl[i]) begin
      cycle(1, tbl[i].ld, tbl[i].sh, tbl[i].sm, tbl[i].im, tbl[i].ih);
      check_time($sformatf("tbl%0d", i), tbl[i].eh, tbl[i].em, tbl[i].es);
      check($sformatf("tbl%0d_tick", i), bus.tick_1hz, tbl[i].et);
      check($sformatf("tbl%0d_err", i), bus.set_error, tbl[i].ee);
      check($sformatf("tbl%0d_wrap", i), bus.day_wrap, 0);
    end

    // Reset and count for 240 cycles
    cycle(0, 0, 0, 0, 0, 0);
    ticks = 0;
    for (int i = 0; i < 240; i++) begin
      cycle(1, 0, 0, 0, 0, 0);
      if (bus.tick_1hz) ticks++;
      if ((i % 4) == 3 || i < 8) check("count_tick_phase", bus.tick_1hz, ((i % 4) == 3) ? 1 : 0);
    end
    check("count_ticks", ticks, 60);
    check_time("count", 0, 1, 0);

    // Day rollover
    cycle(1, 1, 23, 59, 0, 0);
    wraps = 0;
    for (int i = 0; i < 59 * TPS; i++) begin
      cycle(1, 0, 0, 0, 0, 0);
      if (bus.day_wrap) wraps++;
    end
    check_time("pre_wrap", 23, 59, 59);
    for (int i = 0; i < TPS; i++) begin
      cycle(1, 0, 0, 0, 0, 0);
      if (bus.day_wrap) wraps++;
    end
    check_time("wrap", 0, 0, 0);
    check("wrap_pulse", {bus.tick_1hz, bus.day_wrap}, 3);
    idle(8);
    if (bus.day_wrap) wraps++;
    check("wrap_count", wraps, 1);

    // Held inc_min at 10:59:30 steps exactly once
    cycle(1, 1, 10, 59, 0, 0);
    idle(30 * TPS);
    check_time("btn_start", 10, 59, 30);
    cycle(1, 0, 0, 0, 1, 0);
    check_time("btn_step", 10, 0, 30);
    for (int i = 0; i < 9; i++) cycle(1, 0, 0, 0, 1, 0);
    check("btn_hold_min", int'(bus.minutes), 0);
    check("btn_hold_hour", int'(bus.hours), 10);
    cycle(1, 0, 0, 0, 0, 0);

    // inc_hour at 23:15 wraps without day_wrap
    cycle(1, 1, 23, 15, 0, 0);
    cycle(1, 0, 0, 0, 0, 1);
    check_time("hour_wrap", 0, 15, 0);
    check("hour_wrap_nodaywrap", bus.day_wrap, 0);
    cycle(1, 0, 0, 0, 0, 0);

    // 12:59:59 + tick + inc_min edge
    cycle(1, 1, 12, 59, 0, 0);
    idle(59 * TPS);
    check_time("simul_start", 12, 59, 59);
    idle(TPS - 1);
    cycle(1, 0, 0, 0, 1, 0);
    check_time("simul_tick_min", 13, 1, 0);
    check("simul_tick_min_tick", bus.tick_1hz, 1);
    cycle(1, 0, 0, 0, 0, 0);

    // Tick plus valid load suppresses tick
    idle(2);
    cycle(1, 1, 7, 30, 0, 0);
    check_time("tick_load", 7, 30, 0);
    check("tick_load_notick", bus.tick_1hz, 0);

    // Mid-operation reset with set_load held
    cycle(1, 1, 15, 42, 0, 0);
    idle(17 * TPS + 2);
    check_time("midrst_start", 15, 42, 17);
    cycle(0, 1, 15, 42, 1, 1);
    check_time("midrst", 0, 0, 0);
    check("midrst_pulses", {bus.tick_1hz, bus.day_wrap, bus.set_error}, 0);
    idle(TPS - 1);
    check("midrst_notick_yet", int'(bus.seconds), 0);
    idle(1);
    check("midrst_first_tick", {bus.tick_1hz, 2'b00, bus.seconds}, {1'b1, 2'b00, 6'd1});

    // Randomized stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      bit rn, ld, im, ih;
      int sh, sm;
      rn = ($urandom_range(0, 299) != 0);
      ld = ($urandom_range(0, 19) == 0);
      sh = $urandom_range(0, 27);
      sm = $urandom_range(0, 63);
      im = ($urandom_range(0, 3) == 0);
      ih = ($urandom_range(0, 5) == 0);
      cycle(rn, ld, sh, sm, im, ih);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
